// File: rtl/alu_pkg.sv
// alu_pkg: shared command enum and default WIDTH for alu_4b and its bench
package alu_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_SLT = 3'd5,
    ALU_NOT = 3'd6,
    ALU_XOR = 3'd7
  } alu_cmd_e;
endpackage

// File: rtl/alu_if.sv
// alu_if: alu_4b bus (in_valid/a/b/command in; sum/out_valid out; carry/zero only with ALU_FLAGS_EN)
interface alu_if #(parameter int WIDTH = alu_pkg::WIDTH);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       command;
  logic [WIDTH-1:0] sum;
  logic             out_valid;
`ifdef ALU_FLAGS_EN
  logic             carry;
  logic             zero;
  modport master(output in_valid, a, b, command, input sum, out_valid, carry, zero);
  modport slave(input in_valid, a, b, command, output sum, out_valid, carry, zero);
`else
  modport master(output in_valid, a, b, command, input sum, out_valid);
  modport slave(input in_valid, a, b, command, output sum, out_valid);
`endif
endinterface

// File: rtl/alu_comb.sv
// alu_comb: combinational a/b/command -> res (plus carry/zero with ALU_FLAGS_EN)
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       command,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] res
);
  always_comb begin
    res = '0;
    case (alu_cmd_e'(command))
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, a < b};
      ALU_NOT: res = ~a;
      ALU_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end
`ifdef ALU_FLAGS_EN
  assign carry = (command == ALU_ADD) ? (res < a) : (command == ALU_SUB) ? (a < b) : 1'b0;
  assign zero  = (res == '0);
`endif
endmodule

// File: rtl/alu_4b.sv
// alu_4b: registered ALU, 1-cycle latency; ports clk, rst (async high), bus (alu_if.slave); flags via ALU_FLAGS_EN
module alu_4b
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  logic [WIDTH-1:0] res, sum_d, sum_q;
  logic             out_valid_d, out_valid_q;
`ifdef ALU_FLAGS_EN
  logic carry, zero, carry_d, carry_q, zero_d, zero_q;
`endif
  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a(bus.a),
    .b(bus.b),
    .command(bus.command),
`ifdef ALU_FLAGS_EN
    .carry(carry),
    .zero(zero),
`endif
    .res(res)
  );
  always_comb begin
    sum_d       = bus.in_valid ? res : sum_q;
    out_valid_d = bus.in_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.sum       = sum_q;
  assign bus.out_valid = out_valid_q;
`ifdef ALU_FLAGS_EN
  always_comb begin
    carry_d = bus.in_valid ? carry : carry_q;
    zero_d  = bus.in_valid ? zero : zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
`endif
endmodule

// File: tb/tb_alu_4b.sv
// tb_alu_4b: table-driven self-checking bench for alu_4b
module tb_alu_4b;
  import alu_pkg::*;
  typedef struct {
    logic     in_valid;
    int       a;
    int       b;
    alu_cmd_e cmd;
    int       sum;
    logic     ov;
    logic     carry;
    logic     zero;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[15];
  alu_if #(.WIDTH(4)) bus();
  alu_4b #(.WIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input int s, input logic ov, input logic c, input logic z);
    chk({name, "_sum"}, 8'(bus.sum), 8'(s));
    chk({name, "_ov"}, 8'(bus.out_valid), 8'(ov));
`ifdef ALU_FLAGS_EN
    chk({name, "_carry"}, 8'(bus.carry), 8'(c));
    chk({name, "_zero"}, 8'(bus.zero), 8'(z));
`else
    if (c === 1'bx || z === 1'bx) $display("bad vector %s", name);
`endif
  endtask
  task automatic drive(input logic v, input int a, input int b, input alu_cmd_e cmd);
    bus.in_valid = v;
    bus.a        = 4'(a);
    bus.b        = 4'(b);
    bus.command  = cmd;
  endtask
  initial begin
    vecs[0]  = '{1'b1, 10, 1,  ALU_ADD, 11, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 10, 1,  ALU_SUB, 9,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 11, 21, ALU_AND, 1,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 11, 21, ALU_OR,  15, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 15, 0,  ALU_NOT, 0,  1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 15, 12, ALU_SLT, 0,  1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 12, 15, ALU_SLT, 1,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 12, 21, ALU_XOR, 9,  1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 15, 1,  ALU_ADD, 0,  1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 3,  3,  ALU_ADD, 0,  1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3,  3,  ALU_ADD, 0,  1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 3,  5,  ALU_SUB, 14, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 7,  7,  ALU_NOP, 0,  1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 5,  5,  ALU_SUB, 0,  1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 3,  4,  ALU_ADD, 7,  1'b1, 1'b0, 1'b0};
    drive(1'b1, 9, 9, ALU_ADD);
    #2;
    chk_out("reset", 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_out("reset_edge", 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, ALU_NOP);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("idle_after_reset", 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].in_valid, vecs[i].a, vecs[i].b, vecs[i].cmd);
      @(posedge clk);
      #1;
      chk_out($sformatf("row%0d", i), vecs[i].sum, vecs[i].ov, vecs[i].carry, vecs[i].zero);
    end
    drive(1'b1, 1, 1, ALU_ADD);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_out("rst_held", 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("first_after_rst", 2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 0, 0, ALU_NOP);
    @(posedge clk);
    #1;
    chk_out("hold_after_rst", 2, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
